// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares one simple-dual-port block RAM between two masters (M0, M1).
// Port A (byte-write) and port B (registered read) each have their own
// round-robin arbiter. A read that targets the address being written in the
// same cycle is held off for one cycle, because the RAM would otherwise return
// stale data. Read data is returned to the master that issued the read.
//
// Handshake: a master raises mX_req with mX_we/mX_addr/mX_wdata stable and
// keeps them stable until mX_gnt is seen high. The transfer happens in the
// cycle where req=1 and gnt=1. The master may drop req only after gnt.
// gnt is combinational from req/we/addr and registered state, and is never
// high without req. Read data comes back later as mX_rvalid/mX_rdata, with no
// back-pressure. mX_rdata is zero whenever mX_rvalid is low.

module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int OUT_REG    = 0
) (
  input  logic                  clka,
  input  logic                  rst,

  input  logic                  m0_req,
  input  logic [3:0]            m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,

  input  logic                  m1_req,
  input  logic [3:0]            m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,

  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [31:0]           ram_dina,
  output logic [3:0]            ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [31:0]           ram_doutb
);

  // Last winner of each arbiter: 1'b0 = M0, 1'b1 = M1.
  logic                  wptr;
  logic                  rptr;
  // Address last driven onto port B; held while no read is granted.
  logic [ADDR_WIDTH-1:0] addrb_q;
  // Tag of the read issued last cycle: whether it exists and who owns it.
  logic                  rtag_valid;
  logic                  rtag_id;

  logic                  m0_wc, m1_wc;
  logic                  m0_rc, m1_rc;
  logic                  m0_wgnt, m1_wgnt;
  logic                  m0_rsel, m1_rsel;
  logic                  m0_rgnt, m1_rgnt;
  logic                  wr_any, rd_sel_any, rd_any;
  logic                  rd_collide;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_be;

  // Candidate detection, round-robin selection for both ports and the
  // read-after-write collision interlock.
  always_comb begin
    m0_wc      = ~rst & m0_req & (m0_we != 4'b0000);
    m1_wc      = ~rst & m1_req & (m1_we != 4'b0000);
    m0_rc      = ~rst & m0_req & (m0_we == 4'b0000);
    m1_rc      = ~rst & m1_req & (m1_we == 4'b0000);

    // With both candidates present, the master that did not win last time wins.
    m0_wgnt    = m0_wc & (~m1_wc | wptr);
    m1_wgnt    = m1_wc & (~m0_wc | ~wptr);
    m0_rsel    = m0_rc & (~m1_rc | rptr);
    m1_rsel    = m1_rc & (~m0_rc | ~rptr);

    wr_any     = m0_wgnt | m1_wgnt;
    rd_sel_any = m0_rsel | m1_rsel;
    wr_addr    = m1_wgnt ? m1_addr  : m0_addr;
    wr_data    = m1_wgnt ? m1_wdata : m0_wdata;
    wr_be      = m1_wgnt ? m1_we    : m0_we;
    rd_addr    = m1_rsel ? m1_addr  : m0_addr;

    // The RAM returns old data on a same-address A/B collision, so the read
    // waits one cycle and sees the freshly written word instead.
    rd_collide = wr_any & rd_sel_any & (wr_addr == rd_addr);
    m0_rgnt    = m0_rsel & ~rd_collide;
    m1_rgnt    = m1_rsel & ~rd_collide;
    rd_any     = m0_rgnt | m1_rgnt;
  end

  assign m0_gnt = m0_wgnt | m0_rgnt;
  assign m1_gnt = m1_wgnt | m1_rgnt;

  // RAM port drive: write port idles at zero, read port holds its last address.
  always_comb begin
    ram_wea   = 4'b0000;
    ram_addra = '0;
    ram_dina  = 32'h0;
    if (wr_any) begin
      ram_wea   = wr_be;
      ram_addra = wr_addr;
      ram_dina  = wr_data;
    end
    if (rst) begin
      ram_addrb = '0;
    end else if (rd_any) begin
      ram_addrb = rd_addr;
    end else begin
      ram_addrb = addrb_q;
    end
  end

  // Arbiter pointers, held read address and read-return tag.
  always_ff @(posedge clka) begin
    if (rst) begin
      wptr       <= 1'b1;
      rptr       <= 1'b1;
      addrb_q    <= '0;
      rtag_valid <= 1'b0;
      rtag_id    <= 1'b0;
    end else begin
      if (wr_any) begin
        wptr <= m1_wgnt;
      end
      if (rd_any) begin
        rptr    <= m1_rgnt;
        addrb_q <= rd_addr;
        rtag_id <= m1_rgnt;
      end
      rtag_valid <= rd_any;
    end
  end

  // Per-master view of the read data coming out of the RAM this cycle.
  logic m0_rv_c;
  logic m1_rv_c;
  assign m0_rv_c = rtag_valid & ~rtag_id;
  assign m1_rv_c = rtag_valid &  rtag_id;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic        m0_rv_q, m1_rv_q;
      logic [31:0] m0_rd_q, m1_rd_q;

      // Extra return stage: captures the RAM output one cycle later.
      always_ff @(posedge clka) begin
        if (rst) begin
          m0_rv_q <= 1'b0;
          m1_rv_q <= 1'b0;
          m0_rd_q <= 32'h0;
          m1_rd_q <= 32'h0;
        end else begin
          m0_rv_q <= m0_rv_c;
          m1_rv_q <= m1_rv_c;
          m0_rd_q <= m0_rv_c ? ram_doutb : 32'h0;
          m1_rd_q <= m1_rv_c ? ram_doutb : 32'h0;
        end
      end

      assign m0_rvalid = ~rst & m0_rv_q;
      assign m1_rvalid = ~rst & m1_rv_q;
      assign m0_rdata  = rst ? 32'h0 : m0_rd_q;
      assign m1_rdata  = rst ? 32'h0 : m1_rd_q;
    end else begin : g_out_comb
      assign m0_rvalid = ~rst & m0_rv_c;
      assign m1_rvalid = ~rst & m1_rv_c;
      assign m0_rdata  = m0_rvalid ? ram_doutb : 32'h0;
      assign m1_rdata  = m1_rvalid ? ram_doutb : 32'h0;
    end
  endgenerate

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: two instances (OUT_REG=0 and OUT_REG=1) share
// one stimulus stream, each with its own RAM model. A behavioural model of the
// arbitration and memory checks every cycle; directed tests pin it with
// hand-computed values.

module tb_bram_port_arbiter;
  localparam int AW = 12;

  logic          clka = 1'b0;
  logic          rst  = 1'b1;
  int            cyc  = 0;

  logic          req   [2];
  logic [3:0]    we    [2];
  logic [AW-1:0] addr  [2];
  logic [31:0]   wdata [2];

  // Instance A (OUT_REG=0) outputs
  logic          a_m0_gnt, a_m1_gnt, a_m0_rv, a_m1_rv;
  logic [31:0]   a_m0_rd, a_m1_rd;
  logic [AW-1:0] a_addra, a_addrb;
  logic [31:0]   a_dina, a_doutb;
  logic [3:0]    a_wea;
  logic [31:0]   a_mem [0:(1<<AW)-1];

  // Instance B (OUT_REG=1) outputs
  logic          b_m0_gnt, b_m1_gnt, b_m0_rv, b_m1_rv;
  logic [31:0]   b_m0_rd, b_m1_rd;
  logic [AW-1:0] b_addra, b_addrb;
  logic [31:0]   b_dina, b_doutb;
  logic [3:0]    b_wea;
  logic [31:0]   b_mem [0:(1<<AW)-1];

  int ntests = 0;
  int nfails = 0;

  // Model state
  logic [31:0]   exp_mem [0:(1<<AW)-1];
  int            last_w  = 1;
  int            last_r  = 1;
  logic [AW-1:0] last_ra = '0;
  // Entry: {due cycle[30:0], owner id, data}
  logic [63:0]   exp_q0[$];
  logic [63:0]   exp_q1[$];

  // Observed read returns per instance/master
  logic [31:0]   last_rd [2][2];
  int            last_rc [2][2];
  int            rv_n    [2][2];

  bram_port_arbiter #(.ADDR_WIDTH(AW), .OUT_REG(0)) u_a (
    .clka(clka), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rv), .m0_rdata(a_m0_rd),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rv), .m1_rdata(a_m1_rd),
    .ram_addra(a_addra), .ram_dina(a_dina), .ram_wea(a_wea),
    .ram_addrb(a_addrb), .ram_doutb(a_doutb)
  );

  bram_port_arbiter #(.ADDR_WIDTH(AW), .OUT_REG(1)) u_b (
    .clka(clka), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rv), .m0_rdata(b_m0_rd),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rv), .m1_rdata(b_m1_rd),
    .ram_addra(b_addra), .ram_dina(b_dina), .ram_wea(b_wea),
    .ram_addrb(b_addrb), .ram_doutb(b_doutb)
  );

  // Clock
  always #5 clka = ~clka;

  // Cycle counter: number of rising edges so far
  initial forever begin
    @(posedge clka);
    cyc++;
  end

  // RAM models: byte-write port A, registered read port B (old data on collision)
  always @(posedge clka) begin
    for (int b = 0; b < 4; b++) begin
      if (a_wea[b]) a_mem[a_addra][8*b +: 8] <= a_dina[8*b +: 8];
      if (b_wea[b]) b_mem[b_addra][8*b +: 8] <= b_dina[8*b +: 8];
    end
    a_doutb <= a_mem[a_addrb];
    b_doutb <= b_mem[b_addrb];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Every-cycle model and compare, sampled on the falling edge
  initial forever begin
    int            ew, er;
    logic          wc0, wc1, rc0, rc1;
    logic          ev [2];
    logic [31:0]   ed [2];
    logic [63:0]   ent;
    logic          g_act [2];
    logic          v_act [2];
    logic [31:0]   d_act [2];
    logic [3:0]    wea_act;
    logic [AW-1:0] aa_act, ab_act;
    logic [31:0]   di_act;
    @(negedge clka);
    ew = -1;
    er = -1;
    if (!rst) begin
      wc0 = req[0] && (we[0] != 4'b0000);
      wc1 = req[1] && (we[1] != 4'b0000);
      rc0 = req[0] && (we[0] == 4'b0000);
      rc1 = req[1] && (we[1] == 4'b0000);
      if (wc0 && wc1) ew = (last_w == 1) ? 0 : 1;
      else if (wc0)   ew = 0;
      else if (wc1)   ew = 1;
      if (rc0 && rc1) er = (last_r == 1) ? 0 : 1;
      else if (rc0)   er = 0;
      else if (rc1)   er = 1;
      if (er >= 0 && ew >= 0 && addr[er] == addr[ew]) er = -1;
    end
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        g_act[0] = a_m0_gnt; g_act[1] = a_m1_gnt;
        v_act[0] = a_m0_rv;  v_act[1] = a_m1_rv;
        d_act[0] = a_m0_rd;  d_act[1] = a_m1_rd;
        wea_act = a_wea; aa_act = a_addra; di_act = a_dina; ab_act = a_addrb;
      end else begin
        g_act[0] = b_m0_gnt; g_act[1] = b_m1_gnt;
        v_act[0] = b_m0_rv;  v_act[1] = b_m1_rv;
        d_act[0] = b_m0_rd;  d_act[1] = b_m1_rd;
        wea_act = b_wea; aa_act = b_addra; di_act = b_dina; ab_act = b_addrb;
      end
      ev[0] = 1'b0; ev[1] = 1'b0; ed[0] = 32'h0; ed[1] = 32'h0;
      if (!rst) begin
        if (k == 0 && exp_q0.size() > 0 && int'(exp_q0[0][63:33]) == cyc) begin
          ent = exp_q0.pop_front();
          ev[ent[32]] = 1'b1; ed[ent[32]] = ent[31:0];
        end
        if (k == 1 && exp_q1.size() > 0 && int'(exp_q1[0][63:33]) == cyc) begin
          ent = exp_q1.pop_front();
          ev[ent[32]] = 1'b1; ed[ent[32]] = ent[31:0];
        end
      end
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("gnt_i%0d_m%0d", k, m), {31'h0, g_act[m]}, {31'h0, (ew == m) || (er == m)});
        chk($sformatf("rvalid_i%0d_m%0d", k, m), {31'h0, v_act[m]}, {31'h0, ev[m]});
        chk($sformatf("rdata_i%0d_m%0d", k, m), d_act[m], ed[m]);
        if (v_act[m]) begin
          last_rd[k][m] = d_act[m];
          last_rc[k][m] = cyc;
          rv_n[k][m]++;
        end
      end
      chk($sformatf("ram_wea_i%0d", k), {28'h0, wea_act}, (ew >= 0) ? {28'h0, we[ew]} : 32'h0);
      chk($sformatf("ram_addra_i%0d", k), 32'(aa_act), (ew >= 0) ? 32'(addr[ew]) : 32'h0);
      chk($sformatf("ram_dina_i%0d", k), di_act, (ew >= 0) ? wdata[ew] : 32'h0);
      chk($sformatf("ram_addrb_i%0d", k), 32'(ab_act),
          rst ? 32'h0 : ((er >= 0) ? 32'(addr[er]) : 32'(last_ra)));
    end
    // Advance the model
    if (rst) begin
      last_w  = 1;
      last_r  = 1;
      last_ra = '0;
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (er >= 0) begin
        last_r  = er;
        last_ra = addr[er];
        exp_q0.push_back({31'(cyc + 1), (er == 1), exp_mem[addr[er]]});
        exp_q1.push_back({31'(cyc + 2), (er == 1), exp_mem[addr[er]]});
      end
      if (ew >= 0) begin
        last_w = ew;
        for (int b = 0; b < 4; b++)
          if (we[ew][b]) exp_mem[addr[ew]][8*b +: 8] = wdata[ew][8*b +: 8];
      end
    end
  end

  // Driver: present one request for master m and hold it until granted.
  // gc returns the cycle of the grant. Called just after a rising edge.
  task automatic op(input int m, input logic [3:0] w, input logic [AW-1:0] a,
                    input logic [31:0] d, output int gc);
    bit got;
    int n;
    got = 1'b0;
    n   = 0;
    gc  = -1;
    req[m] = 1'b1; we[m] = w; addr[m] = a; wdata[m] = d;
    while (!got && n < 16) begin
      @(negedge clka);
      if ((m == 0) ? a_m0_gnt : a_m1_gnt) begin
        got = 1'b1;
        gc  = cyc;
      end
      @(posedge clka);
      #1;
      n++;
    end
    if (!got) chk($sformatf("op_timeout_m%0d", m), 32'h0, 32'h1);
    req[m] = 1'b0;
    we[m]  = 4'b0000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clka);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  // Directed stimulus
  initial begin
    int g0, g1, g2, g3, rel, x;
    int gl [8];
    int s0, s1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 4'b0000; addr[i] = '0; wdata[i] = 32'h0;
      for (int m = 0; m < 2; m++) begin
        last_rd[i][m] = 32'h0; last_rc[i][m] = -1; rv_n[i][m] = 0;
      end
    end

    // 1: reset with both masters requesting writes
    req[0] = 1'b1; we[0] = 4'hF; addr[0] = 12'h001; wdata[0] = 32'h1111_1111;
    req[1] = 1'b1; we[1] = 4'hF; addr[1] = 12'h002; wdata[1] = 32'h2222_2222;
    idle(3);
    @(negedge clka);
    chk("t1_rst_m0_gnt", {31'h0, a_m0_gnt}, 32'h0);
    chk("t1_rst_m1_gnt", {31'h0, a_m1_gnt}, 32'h0);
    chk("t1_rst_wea", {28'h0, a_wea}, 32'h0);
    @(posedge clka); #1;
    rst = 1'b0;
    rel = cyc;
    fork
      op(0, 4'hF, 12'h001, 32'h1111_1111, g0);
      op(1, 4'hF, 12'h002, 32'h2222_2222, g1);
    join
    chk("t1_m0_first", g0, rel);
    chk("t1_m1_second", g1, rel + 1);

    // 2: write contention, grants alternate
    fork
      begin
        op(0, 4'hF, 12'h010, 32'hAAAA_0010, g0);
        op(0, 4'hF, 12'h010, 32'hCCCC_0010, g2);
      end
      begin
        op(1, 4'hF, 12'h020, 32'hBBBB_0020, g1);
        op(1, 4'hF, 12'h020, 32'hDDDD_0020, g3);
      end
    join
    chk("t2_alt_m1", g1, g0 + 1);
    chk("t2_alt_m0", g2, g0 + 2);
    chk("t2_alt_m1b", g3, g0 + 3);
    op(0, 4'h0, 12'h010, 32'h0, x);
    op(1, 4'h0, 12'h020, 32'h0, x);
    idle(3);
    chk("t2_word_010", last_rd[0][0], 32'hCCCC_0010);
    chk("t2_word_020", last_rd[0][1], 32'hDDDD_0020);
    chk("t2_word_020_oreg", last_rd[1][1], 32'hDDDD_0020);

    // 3: write/read collision on the same address
    fork
      op(0, 4'hF, 12'h055, 32'hA5A5_A5A5, g0);
      op(1, 4'h0, 12'h055, 32'h0, g1);
    join
    idle(3);
    chk("t3_read_stalled", g1, g0 + 1);
    chk("t3_rdata", last_rd[0][1], 32'hA5A5_A5A5);
    chk("t3_rcycle", last_rc[0][1], g1 + 1);
    chk("t3_rdata_oreg", last_rd[1][1], 32'hA5A5_A5A5);
    chk("t3_rcycle_oreg", last_rc[1][1], g1 + 2);

    // 4: byte write merge, then same-master read right after write
    op(1, 4'hF, 12'h030, 32'h1122_3344, x);
    op(1, 4'b0010, 12'h030, 32'h0000_BE00, x);
    op(1, 4'h0, 12'h030, 32'h0, x);
    idle(3);
    chk("t4_byte_merge", last_rd[0][1], 32'h1122_BE44);
    chk("t4_byte_merge_oreg", last_rd[1][1], 32'h1122_BE44);

    // 5: eight back-to-back reads by M0
    for (int i = 0; i < 8; i++) op(1, 4'hF, AW'(i), 32'h5000_0000 + 32'(i) * 32'h111, x);
    s0 = rv_n[0][0];
    s1 = rv_n[1][0];
    for (int i = 0; i < 8; i++) op(0, 4'h0, AW'(i), 32'h0, gl[i]);
    idle(4);
    chk("t5_no_bubble", gl[7], gl[0] + 7);
    chk("t5_count", rv_n[0][0] - s0, 8);
    chk("t5_count_oreg", rv_n[1][0] - s1, 8);
    chk("t5_last_data", last_rd[0][0], 32'h5000_0777);
    chk("t5_latency1", last_rc[0][0], gl[7] + 1);
    chk("t5_latency2", last_rc[1][0], gl[7] + 2);

    // 6: reset the cycle after a read grant; M0 wins both arbiters beforehand
    op(0, 4'hF, 12'h040, 32'h4040_4040, x);
    s0 = rv_n[0][0];
    s1 = rv_n[1][0];
    op(0, 4'h0, 12'h030, 32'h0, x);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(4);
    chk("t6_no_rvalid", rv_n[0][0], s0);
    chk("t6_no_rvalid_oreg", rv_n[1][0], s1);
    rel = cyc;
    fork
      op(0, 4'hF, 12'h041, 32'h0000_0041, g0);
      op(1, 4'hF, 12'h042, 32'h0000_0042, g1);
    join
    chk("t6_wptr_reset", g0, rel);
    chk("t6_wptr_reset_m1", g1, rel + 1);
    rel = cyc;
    fork
      op(0, 4'h0, 12'h041, 32'h0, g0);
      op(1, 4'h0, 12'h042, 32'h0, g1);
    join
    idle(3);
    chk("t6_rptr_reset", g0, rel);
    chk("t6_rptr_reset_m1", g1, rel + 1);
    chk("t6_read_m1_data", last_rd[0][1], 32'h0000_0042);

    $display("[TB] %0d tests run, %0d failed", ntests, nfails);
    $finish;
  end

endmodule
